// File: rtl/rv_multicycle_controller.sv
// Multicycle RV32 control FSM: sequences fetch, decode, memory,
// ALU and branch steps and drives the datapath strobes and selects.
module rv_multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e state_q, state_d;

    logic       pc_we, ir_we, mem_we;
    logic [1:0] alu_op;

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_beq = (op == OP_BEQ);
    assign is_jal = (op == OP_JAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        illegal   = 1'b0;
        unique case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (1'b1)
                    is_lw, is_sw: state_d = MEMADR;
                    is_r:         state_d = EXECR;
                    is_i:         state_d = EXECI;
                    is_beq:       state_d = BEQ;
                    is_jal:       state_d = JAL;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = is_lw ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_we  = 1'b1;
                state_d = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                pc_we   = Zero;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_we   = 1'b1;
                state_d = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write strobes are held off for the whole reset window
    assign PCWrite  = reset_n & pc_we;
    assign IRWrite  = reset_n & ir_we;
    assign MemWrite = reset_n & mem_we;
    assign state    = state_q;

    always_comb begin
        ImmSrc = 2'b00;
        unique case (1'b1)
            is_sw:   ImmSrc = 2'b01;
            is_beq:  ImmSrc = 2'b10;
            is_jal:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        unique case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Directed checks of the multicycle controller state sequence,
// datapath strobes, ALU decode and asynchronous reset.
module tb_rv_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    rv_multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH with mem_ready=1 followed by DECODE
    task automatic fetch_decode(input string tag);
        check({tag, " fetch st"}, 8'(state), 8'd0);
        check({tag, " fetch IRWrite"}, 8'(IRWrite), 8'd1);
        check({tag, " fetch PCWrite"}, 8'(PCWrite), 8'd1);
        tick();
        check({tag, " decode st"}, 8'(state), 8'd1);
        check({tag, " decode srcA"}, 8'(ALUSrcA), 8'd1);
        check({tag, " decode srcB"}, 8'(ALUSrcB), 8'd1);
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        op        = 7'b0000011;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        Zero      = 1'b0;
        mem_ready = 1'b1;

        #12;
        check("rst state", 8'(state), 8'd0);
        check("rst IRWrite", 8'(IRWrite), 8'd0);
        check("rst PCWrite", 8'(PCWrite), 8'd0);
        check("rst MemWrite", 8'(MemWrite), 8'd0);
        check("rst RegWrite", 8'(RegWrite), 8'd0);
        check("rst illegal", 8'(illegal), 8'd0);
        check("rst AdrSrc", 8'(AdrSrc), 8'd0);
        check("rst ResultSrc", 8'(ResultSrc), 8'd2);
        tick();
        check("rst held st", 8'(state), 8'd0);

        // Release away from the clock edge
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // lw: 0,1,2,3,4,0
        fetch_decode("lw");
        check("lw memadr st", 8'(state), 8'd2);
        check("lw memadr srcA", 8'(ALUSrcA), 8'd2);
        check("lw memadr RegWrite", 8'(RegWrite), 8'd0);
        tick();
        check("lw memread st", 8'(state), 8'd3);
        check("lw memread AdrSrc", 8'(AdrSrc), 8'd1);
        check("lw memread RegWrite", 8'(RegWrite), 8'd0);
        tick();
        check("lw memwb st", 8'(state), 8'd4);
        check("lw memwb RegWrite", 8'(RegWrite), 8'd1);
        check("lw memwb ResultSrc", 8'(ResultSrc), 8'd1);
        tick();
        check("lw done st", 8'(state), 8'd0);

        // sw with 3 wait cycles in MEMWRITE
        op = 7'b0100011;
        #1;
        check("sw ImmSrc", 8'(ImmSrc), 8'd1);
        fetch_decode("sw");
        check("sw memadr st", 8'(state), 8'd2);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sw wait st", 8'(state), 8'd5);
            check("sw wait MemWrite", 8'(MemWrite), 8'd1);
            check("sw wait RegWrite", 8'(RegWrite), 8'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("sw last st", 8'(state), 8'd5);
        check("sw last MemWrite", 8'(MemWrite), 8'd1);
        check("sw last AdrSrc", 8'(AdrSrc), 8'd1);
        tick();
        check("sw done st", 8'(state), 8'd0);
        check("sw done MemWrite", 8'(MemWrite), 8'd0);

        // R-type sub and funct3 decode in EXECR
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b1;
        fetch_decode("sub");
        check("sub execr st", 8'(state), 8'd6);
        check("sub ALUControl", 8'(ALUControl), 8'd1);
        check("sub srcA", 8'(ALUSrcA), 8'd2);
        check("sub srcB", 8'(ALUSrcB), 8'd0);
        funct3 = 3'b010; #1;
        check("slt ALUControl", 8'(ALUControl), 8'd5);
        funct3 = 3'b110; #1;
        check("or ALUControl", 8'(ALUControl), 8'd3);
        funct3 = 3'b111; #1;
        check("and ALUControl", 8'(ALUControl), 8'd2);
        funct3 = 3'b001; #1;
        check("f3=1 ALUControl", 8'(ALUControl), 8'd0);
        funct3 = 3'b000;
        tick();
        check("sub aluwb st", 8'(state), 8'd8);
        check("sub aluwb RegWrite", 8'(RegWrite), 8'd1);
        check("sub aluwb ResultSrc", 8'(ResultSrc), 8'd0);
        tick();
        check("sub done st", 8'(state), 8'd0);

        // addi with funct7b5=1 still adds
        op = 7'b0010011;
        fetch_decode("addi");
        check("addi execi st", 8'(state), 8'd7);
        check("addi ALUControl", 8'(ALUControl), 8'd0);
        check("addi srcB", 8'(ALUSrcB), 8'd1);
        tick();
        check("addi aluwb st", 8'(state), 8'd8);
        tick();
        check("addi done st", 8'(state), 8'd0);
        funct7b5 = 1'b0;

        // beq taken then not taken
        op   = 7'b1100011;
        Zero = 1'b1;
        fetch_decode("beqT");
        check("beqT st", 8'(state), 8'd9);
        check("beqT PCWrite", 8'(PCWrite), 8'd1);
        check("beqT ALUControl", 8'(ALUControl), 8'd1);
        check("beqT ImmSrc", 8'(ImmSrc), 8'd2);
        tick();
        check("beqT done st", 8'(state), 8'd0);
        Zero = 1'b0;
        fetch_decode("beqN");
        check("beqN st", 8'(state), 8'd9);
        check("beqN PCWrite", 8'(PCWrite), 8'd0);
        tick();
        check("beqN done st", 8'(state), 8'd0);

        // jal
        op = 7'b1101111;
        fetch_decode("jal");
        check("jal st", 8'(state), 8'd10);
        check("jal PCWrite", 8'(PCWrite), 8'd1);
        check("jal srcA", 8'(ALUSrcA), 8'd1);
        check("jal srcB", 8'(ALUSrcB), 8'd2);
        check("jal ImmSrc", 8'(ImmSrc), 8'd3);
        tick();
        check("jal aluwb st", 8'(state), 8'd8);
        tick();
        check("jal done st", 8'(state), 8'd0);

        // Unsupported opcode
        op = 7'b1111111;
        #1;
        check("ill fetch illegal", 8'(illegal), 8'd0);
        tick();
        check("ill decode st", 8'(state), 8'd1);
        check("ill illegal", 8'(illegal), 8'd1);
        check("ill strobes",
              8'({PCWrite, IRWrite, MemWrite, RegWrite}), 8'd0);
        tick();
        check("ill after st", 8'(state), 8'd0);
        check("ill after illegal", 8'(illegal), 8'd0);

        // Fetch stall
        mem_ready = 1'b0;
        op        = 7'b0000011;
        #1;
        check("stall IRWrite", 8'(IRWrite), 8'd0);
        check("stall PCWrite", 8'(PCWrite), 8'd0);
        tick();
        check("stall st", 8'(state), 8'd0);
        mem_ready = 1'b1;
        tick();
        check("stall decode st", 8'(state), 8'd1);
        tick();
        tick();
        mem_ready = 1'b0;
        check("rmid memread st", 8'(state), 8'd3);
        tick();
        check("rmid hold st", 8'(state), 8'd3);

        // Asynchronous reset mid-cycle during the memory wait
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rmid async st", 8'(state), 8'd0);
        check("rmid IRWrite", 8'(IRWrite), 8'd0);
        check("rmid PCWrite", 8'(PCWrite), 8'd0);
        tick();
        check("rmid held st", 8'(state), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        fetch_decode("post");
        check("post memadr st", 8'(state), 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
